// File: rtl/sub_8bit_pipe.sv
// Two-stage valid/ready 8-bit subtractor: low nibble in S1, high nibble and final borrow in S2.
// Define SUB_SATURATE_EN to clamp negative results to 9'h100 (borrow set, difference zero).
module sub_8bit_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [8:0] diff,
  output logic       out_valid,
  input  logic       out_ready
);

  logic       s1_v_q;
  logic [3:0] s1_lo_q;
  logic       s1_bl_q;
  logic [3:0] s1_ah_q;
  logic [3:0] s1_bh_q;
  logic       s2_v_q;
  logic [8:0] s2_diff_q;

  logic       s1_en;
  logic       s2_en;
  logic [4:0] lo_d;
  logic [4:0] hi_d;
  logic [8:0] res_d;

  // S1 may load whenever S2 is draining in the same edge, giving full-throughput handoff.
  assign s2_en    = !s2_v_q | out_ready;
  assign s1_en    = !s1_v_q | s2_en;
  assign in_ready = s1_en & !rst;

  always_comb begin
    lo_d = {1'b0, a[3:0]} - {1'b0, b[3:0]};
    hi_d = {1'b0, s1_ah_q} - {1'b0, s1_bh_q} - {4'b0000, s1_bl_q};
`ifdef SUB_SATURATE_EN
    res_d = hi_d[4] ? 9'h100 : {1'b0, hi_d[3:0], s1_lo_q};
`else
    res_d = {hi_d[4], hi_d[3:0], s1_lo_q};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_lo_q   <= 4'h0;
      s1_bl_q   <= 1'b0;
      s1_ah_q   <= 4'h0;
      s1_bh_q   <= 4'h0;
      s2_v_q    <= 1'b0;
      s2_diff_q <= 9'h000;
    end else begin
      if (s1_en) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_lo_q <= lo_d[3:0];
          s1_bl_q <= lo_d[4];
          s1_ah_q <= a[7:4];
          s1_bh_q <= b[7:4];
        end
      end
      // Only real transactions overwrite diff, so an idle output keeps its last value.
      if (s2_en) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) s2_diff_q <= res_d;
      end
    end
  end

  assign diff      = s2_diff_q;
  assign out_valid = s2_v_q;

endmodule

// File: tb/tb_sub_8bit_pipe.sv
// Directed and streaming bench for sub_8bit_pipe; expected results are hand-computed or from a reference a-b.
module tb_sub_8bit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] diff;
  logic       out_valid;
  logic       out_ready;

  int n_vec = 0;
  int n_miss = 0;

`ifdef SUB_SATURATE_EN
  localparam logic [8:0] EXP_20_50 = 9'h100;
  localparam logic [8:0] EXP_00_FF = 9'h100;
`else
  localparam logic [8:0] EXP_20_50 = 9'h1D0;
  localparam logic [8:0] EXP_00_FF = 9'h101;
`endif

  always #5 clk = ~clk;

  sub_8bit_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("  ok %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] r;
    r = {1'b0, x} - {1'b0, y};
`ifdef SUB_SATURATE_EN
    if (r[8]) r = 9'h100;
`endif
    return r;
  endfunction

  // Single-transaction latency check with out_ready held high.
  task automatic send_one(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [8:0] exp);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, " in_ready"}, {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    check({tag, " ov_n+0"}, {15'd0, out_valid}, 16'd0);
    tick();
    check({tag, " ov_n+1"}, {15'd0, out_valid}, 16'd1);
    check({tag, " diff"}, {7'd0, diff}, {7'd0, exp});
    tick();
    check({tag, " ov_done"}, {15'd0, out_valid}, 16'd0);
  endtask

  logic [8:0] exp_q[$];
  int         got_cnt;

  initial begin
    rst = 1'b1; a = 8'h00; b = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst out_valid", {15'd0, out_valid}, 16'd0);
    check("rst diff", {7'd0, diff}, 16'd0);
    check("rst in_ready", {15'd0, in_ready}, 16'd0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", {15'd0, in_ready}, 16'd1);

    send_one("50-20", 8'h50, 8'h20, 9'h030);
    send_one("20-50", 8'h20, 8'h50, EXP_20_50);
    send_one("00-FF", 8'h00, 8'hFF, EXP_00_FF);
    send_one("FF-FF", 8'hFF, 8'hFF, 9'h000);
    send_one("10-01", 8'h10, 8'h01, 9'h00F);

    // Backpressure: two accepted, third stalls until out_ready rises.
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h09; b = 8'h01;
    check("bp in_ready#1", {15'd0, in_ready}, 16'd1);
    tick();
    a = 8'h08;
    check("bp in_ready#2", {15'd0, in_ready}, 16'd1);
    tick();
    a = 8'h07;
    #1;
    check("bp in_ready full", {15'd0, in_ready}, 16'd0);
    check("bp diff hold0", {7'd0, diff}, 16'h008);
    tick();
    check("bp in_ready stall", {15'd0, in_ready}, 16'd0);
    check("bp out_valid hold", {15'd0, out_valid}, 16'd1);
    check("bp diff hold1", {7'd0, diff}, 16'h008);
    out_ready = 1'b1;
    #1;
    check("bp in_ready release", {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    check("bp out#2", {7'd0, diff}, 16'h007);
    check("bp ov#2", {15'd0, out_valid}, 16'd1);
    tick();
    check("bp out#3", {7'd0, diff}, 16'h006);
    check("bp ov#3", {15'd0, out_valid}, 16'd1);
    tick();
    check("bp drained", {15'd0, out_valid}, 16'd0);

    // Streaming: one result per cycle against the reference subtraction.
    got_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      if (!in_ready) check("stream in_ready", {15'd0, in_ready}, 16'd1);
      exp_q.push_back(ref_sub(a, b));
      tick();
      if (i >= 1 && !out_valid) check("stream ov", {15'd0, out_valid}, 16'd1);
      if (out_valid) begin
        got_cnt++;
        if (exp_q.size() == 0) check("stream extra", 16'd1, 16'd0);
        else check($sformatf("stream #%0d", got_cnt), {7'd0, diff}, {7'd0, exp_q.pop_front()});
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) begin
        got_cnt++;
        if (exp_q.size() == 0) check("stream extra", 16'd1, 16'd0);
        else check($sformatf("stream #%0d", got_cnt), {7'd0, diff}, {7'd0, exp_q.pop_front()});
      end
    end
    check("stream count", 16'(got_cnt), 16'd256);

    // Reset with two transactions in flight.
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h33; b = 8'h11;
    tick();
    a = 8'h44;
    tick();
    in_valid = 1'b0;
    check("mid pre-rst ov", {15'd0, out_valid}, 16'd1);
    rst = 1'b1;
    #1;
    check("mid rst in_ready", {15'd0, in_ready}, 16'd0);
    tick();
    check("mid rst ov", {15'd0, out_valid}, 16'd0);
    check("mid rst diff", {7'd0, diff}, 16'd0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid no-stale %0d", i), {6'd0, out_valid, diff}, 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
